// File: rtl/stream_split_multicast_pkg.sv
// Shared types and helpers for the stream splitter and its per-port queues.
package stream_split_multicast_pkg;

    typedef enum logic {
        STREAM_SPLIT_MODE_UNICAST,
        STREAM_SPLIT_MODE_MULTICAST
    } stream_split_mode_t;

    // Occupancy needs one extra bit so that a full queue (count == depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_split_queue.sv
// Single-clock per-port FIFO: external push/pop, exposes occupancy, head entry and not_full.
module stream_split_queue
    import stream_split_multicast_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o,
    output logic                       not_full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Guards keep the queue consistent even if a caller pushes when full or pops when empty.
    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o    = count_q;
    assign head_o     = mem_q[rd_ptr_q];
    assign not_full_o = (count_q != CW'(DEPTH));

endmodule

// File: rtl/stream_split_multicast.sv
// Stream demultiplexer: routes each input beat to a unicast id or a multicast mask, one FIFO per port.
module stream_split_multicast
    import stream_split_multicast_pkg::*;
#(
    parameter                     CLOCK_INFO  = 1'b0,
    parameter int                 PORTS       = 4,
    parameter int                 ID_WIDTH    = $clog2(PORTS),
    parameter stream_split_mode_t SPLIT_MODE  = STREAM_SPLIT_MODE_UNICAST,
    parameter int                 DEPTH       = 4,
    parameter int                 COUNT_WIDTH = 16,
    parameter int                 WIDTH       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stream_in_valid_i,
    output logic                           stream_in_ready_o,
    input  logic [WIDTH-1:0]               stream_in_payload_i,
    input  logic [ID_WIDTH-1:0]            stream_in_id_i,
    input  logic [PORTS-1:0]               stream_in_mask_i,
    output logic [PORTS-1:0]               stream_out_valid_o,
    input  logic [PORTS-1:0]               stream_out_ready_i,
    output logic [PORTS-1:0][WIDTH-1:0]    stream_out_payload_o,
    output logic [PORTS-1:0][ID_WIDTH-1:0] stream_out_id_o,
    output logic [COUNT_WIDTH-1:0]         drop_count_o
);

    localparam int CW = cnt_width(DEPTH);

    if (PORTS < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || $bits(CLOCK_INFO) == 0) begin : g_bad_params
        $error("stream_split_multicast: PORTS must be >= 2 and DEPTH a power of two >= 2");
    end

    logic [PORTS-1:0]       target;
    logic [PORTS-1:0]       not_full;
    logic [PORTS-1:0]       push;
    logic                   accept;
    logic [COUNT_WIDTH-1:0] drop_q, drop_d;

    // An out-of-range id matches no port and so yields an empty target set.
    always_comb begin
        target = '0;
        if (SPLIT_MODE == STREAM_SPLIT_MODE_MULTICAST) begin
            target = stream_in_mask_i;
        end else begin
            for (int k = 0; k < PORTS; k++) begin
                target[k] = (stream_in_id_i == ID_WIDTH'(k));
            end
        end
    end

    // All targets must have room, so a multicast beat is never delivered partially.
    assign stream_in_ready_o = !rst && (&(~target | not_full));
    assign accept            = stream_in_valid_i && stream_in_ready_o;
    assign push              = accept ? target : '0;

    always_comb begin
        drop_d = drop_q;
        if (accept && (target == '0) && (drop_q != '1)) begin
            drop_d = drop_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count_o = drop_q;

    for (genvar k = 0; k < PORTS; k++) begin : g_port
        logic [CW-1:0] count;

        stream_split_queue #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_queue (
            .clk         (clk),
            .rst         (rst),
            .push_i      (push[k]),
            .push_data_i (stream_in_payload_i),
            .pop_i       (stream_out_valid_o[k] && stream_out_ready_i[k]),
            .count_o     (count),
            .head_o      (stream_out_payload_o[k]),
            .not_full_o  (not_full[k])
        );

        assign stream_out_valid_o[k] = (count != '0);
        assign stream_out_id_o[k]    = ID_WIDTH'(k);
    end

endmodule

// File: tb/tb_stream_split_multicast.sv
// Directed bench: unicast (4 and 3 ports) and multicast splitters checked against hand-computed values.
module tb_stream_split_multicast;
    import stream_split_multicast_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // u: 4-port unicast
    logic             u_rst, u_iv, u_ir;
    logic [7:0]       u_ip;
    logic [1:0]       u_id;
    logic [3:0]       u_mask, u_ov, u_or;
    logic [3:0][7:0]  u_op;
    logic [3:0][1:0]  u_oid;
    logic [15:0]      u_drop;

    // t: 3-port unicast
    logic             t_rst, t_iv, t_ir;
    logic [7:0]       t_ip;
    logic [1:0]       t_id;
    logic [2:0]       t_mask, t_ov, t_or;
    logic [2:0][7:0]  t_op;
    logic [2:0][1:0]  t_oid;
    logic [15:0]      t_drop;

    // m: 4-port multicast
    logic             m_rst, m_iv, m_ir;
    logic [7:0]       m_ip;
    logic [1:0]       m_id;
    logic [3:0]       m_mask, m_ov, m_or;
    logic [3:0][7:0]  m_op;
    logic [3:0][1:0]  m_oid;
    logic [15:0]      m_drop;

    stream_split_multicast #(.PORTS(4), .SPLIT_MODE(STREAM_SPLIT_MODE_UNICAST), .DEPTH(4)) dut_u (
        .clk(clk), .rst(u_rst), .stream_in_valid_i(u_iv), .stream_in_ready_o(u_ir),
        .stream_in_payload_i(u_ip), .stream_in_id_i(u_id), .stream_in_mask_i(u_mask),
        .stream_out_valid_o(u_ov), .stream_out_ready_i(u_or), .stream_out_payload_o(u_op),
        .stream_out_id_o(u_oid), .drop_count_o(u_drop));

    stream_split_multicast #(.PORTS(3), .SPLIT_MODE(STREAM_SPLIT_MODE_UNICAST), .DEPTH(4)) dut_t (
        .clk(clk), .rst(t_rst), .stream_in_valid_i(t_iv), .stream_in_ready_o(t_ir),
        .stream_in_payload_i(t_ip), .stream_in_id_i(t_id), .stream_in_mask_i(t_mask),
        .stream_out_valid_o(t_ov), .stream_out_ready_i(t_or), .stream_out_payload_o(t_op),
        .stream_out_id_o(t_oid), .drop_count_o(t_drop));

    stream_split_multicast #(.PORTS(4), .SPLIT_MODE(STREAM_SPLIT_MODE_MULTICAST), .DEPTH(4)) dut_m (
        .clk(clk), .rst(m_rst), .stream_in_valid_i(m_iv), .stream_in_ready_o(m_ir),
        .stream_in_payload_i(m_ip), .stream_in_id_i(m_id), .stream_in_mask_i(m_mask),
        .stream_out_valid_o(m_ov), .stream_out_ready_i(m_or), .stream_out_payload_o(m_op),
        .stream_out_id_o(m_oid), .drop_count_o(m_drop));

    typedef struct {
        bit         to_m;
        logic [1:0] id;
        logic [3:0] mask;
        logic [7:0] data;
        logic [3:0] exp_v;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 2'd0, 4'b0000, 8'hA0, 4'b0001, 16'd0};
        vecs[1] = '{1'b0, 2'd1, 4'b0000, 8'hA1, 4'b0010, 16'd0};
        vecs[2] = '{1'b0, 2'd2, 4'b0000, 8'hA2, 4'b0100, 16'd0};
        vecs[3] = '{1'b0, 2'd3, 4'b0000, 8'hA3, 4'b1000, 16'd0};
        vecs[4] = '{1'b1, 2'd0, 4'b1011, 8'h55, 4'b1011, 16'd0};
        vecs[5] = '{1'b1, 2'd0, 4'b0100, 8'h66, 4'b0100, 16'd0};
        vecs[6] = '{1'b1, 2'd0, 4'b0000, 8'h77, 4'b0000, 16'd1};
        vecs[7] = '{1'b1, 2'd0, 4'b1111, 8'h88, 4'b1111, 16'd1};

        u_rst = 1; t_rst = 1; m_rst = 1;
        u_iv = 0; t_iv = 0; m_iv = 0;
        u_ip = 0; t_ip = 0; m_ip = 0;
        u_id = 0; t_id = 0; m_id = 0;
        u_mask = 0; t_mask = 0; m_mask = 0;
        u_or = 4'hF; t_or = 3'h7; m_or = 4'hF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        u_iv = 1;
        #1;
        chk("ready_in_reset", {31'd0, u_ir}, 32'd0);
        u_iv = 0;
        chk("u_valid_reset", {28'd0, u_ov}, 32'd0);
        chk("m_valid_reset", {28'd0, m_ov}, 32'd0);
        chk("u_drop_reset", {16'd0, u_drop}, 32'd0);
        chk("u_out_id", {24'd0, u_oid}, 32'h0000_00E4);
        chk("t_out_id", {26'd0, t_oid}, 32'h0000_0024);
        @(negedge clk);
        u_rst = 0; t_rst = 0; m_rst = 0;

        // Table-driven single beats, all consumers ready
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (vecs[i].to_m) begin
                u_iv = 0; m_iv = 1; m_mask = vecs[i].mask; m_ip = vecs[i].data;
            end else begin
                m_iv = 0; u_iv = 1; u_id = vecs[i].id; u_ip = vecs[i].data;
            end
            #1;
            chk($sformatf("vec%0d_ready", i), {31'd0, vecs[i].to_m ? m_ir : u_ir}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), {28'd0, vecs[i].to_m ? m_ov : u_ov}, {28'd0, vecs[i].exp_v});
            for (int p = 0; p < 4; p++) begin
                if (vecs[i].exp_v[p]) begin
                    chk($sformatf("vec%0d_data_p%0d", i, p),
                        {24'd0, vecs[i].to_m ? m_op[p] : u_op[p]}, {24'd0, vecs[i].data});
                end
            end
            chk($sformatf("vec%0d_drop", i), {16'd0, vecs[i].to_m ? m_drop : u_drop}, {16'd0, vecs[i].exp_drop});
        end
        @(negedge clk);
        u_iv = 0; m_iv = 0;
        @(posedge clk);
        #1;
        chk("u_single_beat", {28'd0, u_ov}, 32'd0);
        chk("m_single_beat", {28'd0, m_ov}, 32'd0);

        // 3 ports: id 3 is out of range and dropped
        @(negedge clk);
        t_iv = 1; t_id = 2'd3; t_ip = 8'h99;
        #1;
        chk("t_oor_ready", {31'd0, t_ir}, 32'd1);
        @(posedge clk);
        #1;
        t_iv = 0;
        chk("t_oor_valid", {29'd0, t_ov}, 32'd0);
        chk("t_oor_drop", {16'd0, t_drop}, 32'd1);
        @(posedge clk);
        #1;
        chk("t_oor_valid2", {29'd0, t_ov}, 32'd0);

        // Port 2 stalled: four beats fit, fifth stalls
        @(negedge clk);
        u_or[2] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            u_iv = 1; u_id = 2'd2; u_ip = 8'(i);
            #1;
            chk($sformatf("stall_ready_%0d", i), {31'd0, u_ir}, (i <= 4) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        chk("stall_head_valid", {31'd0, u_ov[2]}, 32'd1);
        chk("stall_head_data", {24'd0, u_op[2]}, 32'd1);
        @(negedge clk);
        u_id = 2'd0; u_ip = 8'h77;
        #1;
        chk("other_port_ready", {31'd0, u_ir}, 32'd1);
        @(posedge clk);
        #1;
        chk("other_port_valid", {31'd0, u_ov[0]}, 32'd1);
        chk("other_port_data", {24'd0, u_op[0]}, 32'h77);
        u_id = 2'd2; u_ip = 8'd5; u_or[2] = 1'b1;
        got.delete();
        begin
            bit sent = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (sent) u_iv = 0;
                #1;
                if (c == 0) chk("full_pop_still_stalls", {31'd0, u_ir}, 32'd0);
                if (u_ov[2]) got.push_back(u_op[2]);
                if (u_iv && u_ir) sent = 1;
            end
        end
        chk("drain_len", got.size(), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            chk($sformatf("drain_%0d", i), {24'd0, got[i]}, i + 1);
        end

        // Multicast with one full target stalls the whole beat
        @(negedge clk);
        m_or[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_iv = 1; m_mask = 4'b0010; m_ip = 8'h10 + 8'(i);
            #1;
            chk($sformatf("mc_fill_ready_%0d", i), {31'd0, m_ir}, 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        m_mask = 4'b0011; m_ip = 8'h55;
        #1;
        chk("mc_full_ready", {31'd0, m_ir}, 32'd0);
        @(posedge clk);
        #1;
        chk("mc_p0_nothing", {31'd0, m_ov[0]}, 32'd0);
        @(negedge clk);
        m_or[1] = 1'b1;
        #1;
        chk("mc_full_pop_ready", {31'd0, m_ir}, 32'd0);
        @(negedge clk);
        m_or[1] = 1'b0;
        #1;
        chk("mc_after_pop_ready", {31'd0, m_ir}, 32'd1);
        chk("mc_p0_still_nothing", {31'd0, m_ov[0]}, 32'd0);
        @(posedge clk);
        #1;
        m_iv = 0;
        chk("mc_p0_valid", {31'd0, m_ov[0]}, 32'd1);
        chk("mc_p0_data", {24'd0, m_op[0]}, 32'h55);
        m_or[1] = 1'b1;
        got.delete();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (m_ov[1]) got.push_back(m_op[1]);
        end
        chk("mc_p0_one_beat", {31'd0, m_ov[0]}, 32'd0);
        chk("mc_p1_len", got.size(), 32'd4);
        if (got.size() == 4) begin
            chk("mc_p1_d0", {24'd0, got[0]}, 32'h11);
            chk("mc_p1_d2", {24'd0, got[2]}, 32'h13);
            chk("mc_p1_d3", {24'd0, got[3]}, 32'h55);
        end

        // Mid-operation reset discards queued beats and clears drop count
        @(negedge clk);
        t_or = 3'b000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            t_iv = 1; t_id = (i < 3) ? 2'd0 : 2'd1; t_ip = ((i < 3) ? 8'h30 : 8'h40) + 8'(i % 3);
            #1;
            chk($sformatf("rst_fill_ready_%0d", i), {31'd0, t_ir}, 32'd1);
            @(posedge clk);
            #1;
        end
        chk("rst_pre_valid", {29'd0, t_ov}, 32'b011);
        chk("rst_pre_drop", {16'd0, t_drop}, 32'd1);
        @(negedge clk);
        t_iv = 0; t_rst = 1;
        #1;
        chk("rst_ready_low", {31'd0, t_ir}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_post_valid", {29'd0, t_ov}, 32'd0);
        chk("rst_post_drop", {16'd0, t_drop}, 32'd0);
        @(negedge clk);
        t_rst = 0; t_iv = 1; t_id = 2'd0; t_ip = 8'hEE;
        #1;
        chk("rst_fresh_ready", {31'd0, t_ir}, 32'd1);
        @(posedge clk);
        #1;
        t_iv = 0;
        chk("rst_fresh_valid", {29'd0, t_ov}, 32'b001);
        chk("rst_fresh_data", {24'd0, t_op[0]}, 32'hEE);
        t_or = 3'b111;
        @(posedge clk);
        #1;
        chk("rst_only_new", {29'd0, t_ov}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
